// File: rtl/timer_pkg.sv
// Shared constants and types for timer_core: register offsets, TCR layout and reset values.
package timer_pkg;

  localparam logic [31:0] TCR_OFS   = 32'h00;
  localparam logic [31:0] TDR0_OFS  = 32'h04;
  localparam logic [31:0] TDR1_OFS  = 32'h08;
  localparam logic [31:0] TCMP0_OFS = 32'h0C;
  localparam logic [31:0] TCMP1_OFS = 32'h10;
  localparam logic [31:0] TIER_OFS  = 32'h14;
  localparam logic [31:0] TISR_OFS  = 32'h18;

  localparam int unsigned TCR_EN_BIT    = 0;
  localparam int unsigned TCR_DIVEN_BIT = 1;
  localparam int unsigned TCR_DIV_LSB   = 8;
  localparam int unsigned TCR_DIV_MSB   = 11;

  typedef struct packed {
    logic [3:0] div_val;
    logic       div_en;
    logic       timer_en;
  } tcr_t;

  localparam tcr_t TCR_RST = '{div_val: 4'd1, div_en: 1'b0, timer_en: 1'b0};

  function automatic logic [31:0] tcr_pack(tcr_t t);
    logic [31:0] v;
    v = '0;
    v[TCR_EN_BIT]                  = t.timer_en;
    v[TCR_DIVEN_BIT]               = t.div_en;
    v[TCR_DIV_MSB:TCR_DIV_LSB]     = t.div_val;
    return v;
  endfunction

endpackage

// File: rtl/timer_if.sv
// Simple memory-mapped peripheral bus between the bridge (master) and timer_core (slave).
interface timer_if;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output wr_en, output wdata, input rdata, input irq);
  modport slave  (input addr, input wr_en, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: tick every cycle, or once per 2^div_val cycles when div_en is set.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_timer_en,
  input  logic       i_div_en,
  input  logic [3:0] i_div_val,
  input  logic       i_clr,
  input  logic       i_hold,
  output logic       o_tick
);

  logic [15:0] r_psc;
  logic [15:0] w_term;

  assign w_term = (16'd1 << i_div_val) - 16'd1;
  assign o_tick = !i_div_en || (r_psc == w_term);

  // A clear (timer off or TCR write) beats hold so a reconfigure always restarts the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (!i_timer_en || i_clr) begin
      r_psc <= '0;
    end else if (i_hold) begin
      r_psc <= r_psc;
    end else if (!i_div_en || o_tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 16'd1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Timer core: TCR, prescaled free-running counter, compare and sticky match interrupt.
// Optional macro TIMER_HALT_EN adds the i_dbg_halt counter-freeze input.
module timer_core
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned DIV_MAX   = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TIMER_HALT_EN
  input  logic i_dbg_halt,
`endif
  timer_if.slave bus
);

  localparam logic [3:0] DIV_MAX_V = 4'(DIV_MAX);
  localparam bit         HAS_HI    = (CNT_W > 32);

  tcr_t             r_tcr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cmp;
  logic             r_int_en;
  logic             r_int_st;

  logic [31:0]      w_ofs;
  logic             w_wr_tcr, w_wr_tdr0, w_wr_tdr1, w_wr_tcmp0, w_wr_tcmp1;
  logic             w_wr_tier, w_clr_st;
  logic             w_tick, w_halt, w_match;
  logic [63:0]      w_cnt64, w_cmp64;
  logic [CNT_W-1:0] w_cnt_d, w_cmp_d;

`ifdef TIMER_HALT_EN
  assign w_halt = i_dbg_halt;
`else
  assign w_halt = 1'b0;
`endif

  assign w_ofs      = bus.addr - BASE_ADDR;
  assign w_wr_tcr   = bus.wr_en && (w_ofs == TCR_OFS);
  assign w_wr_tdr0  = bus.wr_en && (w_ofs == TDR0_OFS);
  assign w_wr_tdr1  = bus.wr_en && (w_ofs == TDR1_OFS) && HAS_HI;
  assign w_wr_tcmp0 = bus.wr_en && (w_ofs == TCMP0_OFS);
  assign w_wr_tcmp1 = bus.wr_en && (w_ofs == TCMP1_OFS) && HAS_HI;
  assign w_wr_tier  = bus.wr_en && (w_ofs == TIER_OFS);
  assign w_clr_st   = bus.wr_en && (w_ofs == TISR_OFS) && bus.wdata[0];

  // Widen to 64 bits so the high-half slices stay legal when CNT_W is 32.
  assign w_cnt64 = 64'(r_cnt);
  assign w_cmp64 = 64'(r_cmp);
  assign w_match = (r_cnt == r_cmp);

  timer_prescaler u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_timer_en (r_tcr.timer_en),
    .i_div_en   (r_tcr.div_en),
    .i_div_val  (r_tcr.div_val),
    .i_clr      (w_wr_tcr),
    .i_hold     (w_halt),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_wr_tdr0) begin
      w_cnt_d = CNT_W'({w_cnt64[63:32], bus.wdata});
    end else if (w_wr_tdr1) begin
      w_cnt_d = CNT_W'({bus.wdata, w_cnt64[31:0]});
    end else if (r_tcr.timer_en && w_tick && !w_halt) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_cmp_d = r_cmp;
    if (w_wr_tcmp0) begin
      w_cmp_d = CNT_W'({w_cmp64[63:32], bus.wdata});
    end else if (w_wr_tcmp1) begin
      w_cmp_d = CNT_W'({bus.wdata, w_cmp64[31:0]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcr    <= TCR_RST;
      r_cnt    <= '0;
      r_cmp    <= '1;
      r_int_en <= 1'b0;
      r_int_st <= 1'b0;
    end else begin
      if (w_wr_tcr) begin
        r_tcr.timer_en <= bus.wdata[TCR_EN_BIT];
        r_tcr.div_en   <= bus.wdata[TCR_DIVEN_BIT];
        if (bus.wdata[TCR_DIV_MSB:TCR_DIV_LSB] <= DIV_MAX_V) begin
          r_tcr.div_val <= bus.wdata[TCR_DIV_MSB:TCR_DIV_LSB];
        end
      end
      r_cnt <= w_cnt_d;
      r_cmp <= w_cmp_d;
      if (w_wr_tier) begin
        r_int_en <= bus.wdata[0];
      end
      // Match wins over a same-cycle clear.
      r_int_st <= w_match || (r_int_st && !w_clr_st);
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (w_ofs)
      TCR_OFS:   bus.rdata = tcr_pack(r_tcr);
      TDR0_OFS:  bus.rdata = w_cnt64[31:0];
      TDR1_OFS:  bus.rdata = w_cnt64[63:32];
      TCMP0_OFS: bus.rdata = w_cmp64[31:0];
      TCMP1_OFS: bus.rdata = w_cmp64[63:32];
      TIER_OFS:  bus.rdata = {31'd0, r_int_en};
      TISR_OFS:  bus.rdata = {31'd0, r_int_st};
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.irq = r_int_st && r_int_en;

endmodule

// File: tb/tb_timer_core.sv
// Randomised self-checking bench for timer_core against a cycle-level arithmetic model.
module tb_timer_core;

  localparam logic [31:0] BASE    = 32'h2000_0000;
  localparam int unsigned DIV_MAX = 8;
  localparam logic [31:0] O_TCR = 32'h00, O_TDR0 = 32'h04, O_TDR1 = 32'h08, O_TCMP0 = 32'h0C;
  localparam logic [31:0] O_TCMP1 = 32'h10, O_TIER = 32'h14, O_TISR = 32'h18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halt = 1'b0;

  timer_if bus ();

  timer_core #(
    .BASE_ADDR (BASE),
    .CNT_W     (64),
    .DIV_MAX   (DIV_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TIMER_HALT_EN
    .i_dbg_halt (halt),
`endif
    .bus        (bus)
  );

  always #50 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference state: architectural values only; prescaler phase as cycles since last restart.
  logic             m_en, m_div_en;
  logic [3:0]       m_dv;
  longint unsigned  m_age;
  logic [63:0]      m_cnt, m_cmp;
  logic             m_int_en, m_int_st;

  task automatic model_reset();
    m_en = 0; m_div_en = 0; m_dv = 4'd1; m_age = 0;
    m_cnt = '0; m_cmp = '1; m_int_en = 0; m_int_st = 0;
  endtask

  task automatic model_step();
    logic [31:0]     ofs;
    logic [31:0]     d;
    logic            wr, match, inc, halted;
    longint unsigned period;
    ofs    = bus.addr - BASE;
    d      = bus.wdata;
    wr     = bus.wr_en;
    halted = halt;
`ifndef TIMER_HALT_EN
    halted = 1'b0;
`endif
    match  = (m_cnt == m_cmp);
    period = 64'd1 << m_dv;
    inc    = m_en && !halted && (!m_div_en || ((m_age + 1) % period == 0));
    if (!m_en || (wr && ofs == O_TCR)) m_age = 0;
    else if (!halted) m_age = m_age + 1;
    if (wr && ofs == O_TDR0) m_cnt[31:0] = d;
    else if (wr && ofs == O_TDR1) m_cnt[63:32] = d;
    else if (inc) m_cnt = m_cnt + 64'd1;
    m_int_st = match || (m_int_st && !(wr && ofs == O_TISR && d[0]));
    if (wr && ofs == O_TCR) begin
      m_en = d[0];
      m_div_en = d[1];
      if (d[11:8] <= 4'(DIV_MAX)) m_dv = d[11:8];
    end
    if (wr && ofs == O_TCMP0) m_cmp[31:0] = d;
    if (wr && ofs == O_TCMP1) m_cmp[63:32] = d;
    if (wr && ofs == O_TIER) m_int_en = d[0];
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] ofs);
    case (ofs)
      O_TCR:   return {20'd0, m_dv, 6'd0, m_div_en, m_en};
      O_TDR0:  return m_cnt[31:0];
      O_TDR1:  return m_cnt[63:32];
      O_TCMP0: return m_cmp[31:0];
      O_TCMP1: return m_cmp[63:32];
      O_TIER:  return {31'd0, m_int_en};
      O_TISR:  return {31'd0, m_int_st};
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.wr_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
    bus.addr = BASE + ofs; bus.wdata = d; bus.wr_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] ofs, output logic [31:0] v);
    bus.addr = BASE + ofs;
    #1;
    v = bus.rdata;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] ofs);
    logic [31:0] v;
    rd(ofs, v);
    check_eq($sformatf("%s@%02h", tag, ofs), v, m_read(ofs));
  endtask

  task automatic chk_irq(input string tag);
    check_eq({tag, "_irq"}, {31'd0, bus.irq}, {31'd0, m_int_st & m_int_en});
  endtask

  task automatic chk_all(input string tag);
    for (int o = 0; o <= 24; o += 4) chk_reg(tag, 32'(o));
    chk_irq(tag);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] held;
    bit          found;
    bus.addr = BASE; bus.wdata = '0; bus.wr_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values, against constants and the model.
    rd(O_TCR, v);   check_eq("rst_tcr", v, 32'h0000_0100);
    rd(O_TDR0, v);  check_eq("rst_tdr0", v, 32'h0);
    rd(O_TDR1, v);  check_eq("rst_tdr1", v, 32'h0);
    rd(O_TCMP0, v); check_eq("rst_tcmp0", v, 32'hFFFF_FFFF);
    rd(O_TCMP1, v); check_eq("rst_tcmp1", v, 32'hFFFF_FFFF);
    rd(O_TIER, v);  check_eq("rst_tier", v, 32'h0);
    rd(O_TISR, v);  check_eq("rst_tisr", v, 32'h0);
    check_eq("rst_irq", {31'd0, bus.irq}, 32'd0);

    // Out-of-range div_val is rejected, other fields still land.
    wr(O_TCR, 32'h0000_0901);
    rd(O_TCR, v);   check_eq("tcr_divmax", v, 32'h0000_0101);
    idle(5);
    chk_reg("run_en", O_TDR0);

    // Divide by 8 for 40 cycles from zero.
    wr(O_TCR, 32'h0);
    wr(O_TDR0, 32'h0);
    wr(O_TDR1, 32'h0);
    wr(O_TCR, 32'h0000_0303);
    idle(40);
    rd(O_TDR0, v);  check_eq("div8_cnt", v, 32'd5);
    chk_reg("div8", O_TDR0);

    // Wrap from all ones.
    wr(O_TCR, 32'h0);
    wr(O_TDR0, 32'hFFFF_FFFF);
    wr(O_TDR1, 32'hFFFF_FFFF);
    wr(O_TCR, 32'h1);
    step();
    rd(O_TDR0, v);  check_eq("wrap_lo", v, 32'h0);
    rd(O_TDR1, v);  check_eq("wrap_hi", v, 32'h0);
    check_eq("wrap_irq", {31'd0, bus.irq}, 32'd0);
    chk_all("wrap");

    // Compare match at 20.
    wr(O_TCR, 32'h0);
    wr(O_TDR0, 32'h0);
    wr(O_TDR1, 32'h0);
    wr(O_TCMP0, 32'd20);
    wr(O_TCMP1, 32'd0);
    wr(O_TISR, 32'h1);
    wr(O_TIER, 32'h1);
    wr(O_TCR, 32'h1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      rd(O_TDR0, v);
      if (v == 32'd20) found = 1;
      else step();
    end
    check_eq("reach20", v, 32'd20);
    check_eq("pre_match_irq", {31'd0, bus.irq}, 32'd0);
    step();
    check_eq("match_irq", {31'd0, bus.irq}, 32'd1);
    rd(O_TISR, v);  check_eq("match_tisr", v, 32'd1);
    wr(O_TISR, 32'h1);
    check_eq("clr_irq", {31'd0, bus.irq}, 32'd0);
    chk_all("clr");

    // Stopped on a match: masked irq, and clear loses to the persisting match.
    wr(O_TCR, 32'h0);
    wr(O_TCMP0, m_cnt[31:0]);
    step();
    wr(O_TIER, 32'h0);
    check_eq("mask_irq", {31'd0, bus.irq}, 32'd0);
    rd(O_TISR, v);  check_eq("mask_tisr", v, 32'd1);
    wr(O_TISR, 32'h1);
    rd(O_TISR, v);  check_eq("reset_wins", v, 32'd1);
    chk_all("stopmatch");

    // Unmapped offsets.
    wr(32'h1C, 32'hDEAD_BEEF);
    rd(32'h1C, v);  check_eq("unmapped_1c", v, 32'd0);
    rd(32'hFFFF_FFFC, v); check_eq("unmapped_below", v, 32'd0);

`ifdef TIMER_HALT_EN
    wr(O_TCMP1, 32'hFFFF_FFFF);
    wr(O_TCR, 32'h1);
    idle(3);
    halt = 1'b1;
    rd(O_TDR0, held);
    idle(10);
    rd(O_TDR0, v);  check_eq("halt_hold", v, held);
    wr(O_TDR0, 32'd7);
    rd(O_TDR0, v);  check_eq("halt_load", v, 32'd7);
    halt = 1'b0;
    idle(3);
    rd(O_TDR0, v);  check_eq("halt_resume", v, 32'd10);
    chk_all("halt");
`else
    held = 32'd0;
`endif

    // Randomised register traffic.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] d;
      int unsigned op;
      op = $urandom_range(0, 8);
      case (op)
        0: begin
          d = $urandom;
          d[0] = ($urandom_range(0, 3) != 0);
          wr(O_TCR, d);
        end
        1: wr(O_TDR0, $urandom);
        2: wr(O_TDR1, $urandom_range(0, 1));
        3: wr(O_TCMP0, m_cnt[31:0] + $urandom_range(0, 40));
        4: wr(O_TCMP1, m_cnt[63:32]);
        5: wr(O_TIER, $urandom_range(0, 1));
        6: wr(O_TISR, $urandom_range(0, 1));
        7: wr(32'h1C + 32'($urandom_range(0, 3) * 4), $urandom);
        default: idle($urandom_range(1, 60));
      endcase
`ifdef TIMER_HALT_EN
      if ($urandom_range(0, 5) == 0) halt = ~halt;
`endif
      idle($urandom_range(0, 5));
      chk_all($sformatf("rnd%0d", it));
    end
    halt = 1'b0;

    // Asynchronous reset mid-count.
    wr(O_TCR, 32'h1);
    idle(7);
    #20;
    rst_n = 1'b0;
    #1;
    rd(O_TDR0, v);  check_eq("async_rst_cnt", v, 32'd0);
    rd(O_TCR, v);   check_eq("async_rst_tcr", v, 32'h0000_0100);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
